jtag_vpi_core: RTL and testbench
================================

# jtag_vpi_core

Synthesizable JTAG master that turns host commands into TCK/TMS/TDI bit sequences and captures TDO. It sits between the bench/host command channel and the SoC debug TAP pins (tms_pad_i/tck_pad_i/tdi_pad_i/tdo_pad_o). Command processing is gated by an enable input and by an init-done indication from the SoC.

## Interface
- TCK_HALF, default 2: system clocks per TCK half-period (≥1).
- MAX_BITS, default 64: scan/TMS buffer length in bits.
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- enable  in  1  command acceptance enable.
- init_done  in  1  SoC init indication; first high level arms the block (sticky).
- cmd_valid / cmd_ready  in / out  1  command handshake; transfer when both high.
- cmd_op  in  3  0 RESET, 1 TMS_SEQ, 2 SCAN, 3 SCAN_FLIP_TMS, 4 STOP; others are ignored (accepted, no action).
- cmd_len  in  7  bit count, 0..MAX_BITS; values >MAX_BITS clamp to MAX_BITS.
- cmd_data  in  MAX_BITS  TMS or TDI bits, LSB sent first.
- rsp_valid / rsp_ready  out / in  1  response handshake (SCAN ops only).
- rsp_data  out  MAX_BITS  captured TDO, bit i = TDO sampled on bit i.
- stop  out  1  one-cycle pulse on STOP.
- tck, tms, tdi  out  1  JTAG drive; tdo  in  1  JTAG return.

## Operation
- States: WAIT_INIT, IDLE, LOW, HIGH, RESP.
- WAIT_INIT: after reset; move to IDLE on first cycle init_done=1.
- IDLE: cmd_ready = enable. On transfer, latch op/len/data; RESET loads 6 bits with TMS pattern 1,1,1,1,1,0; TMS_SEQ drives cmd_data on TMS, TDI=0; SCAN drives cmd_data on TDI, TMS=0; SCAN_FLIP_TMS as SCAN but TMS=1 on the last bit; STOP pulses stop next cycle and returns to IDLE.
- Bit sequencing: LOW sets tms/tdi for the current bit with tck=0 for TCK_HALF clocks; HIGH drives tck=1 for TCK_HALF clocks, samples tdo into the capture register on entry to HIGH (rising TCK edge); then the next bit or finish.
- Finish: SCAN ops go to RESP (rsp_valid=1 until rsp_ready), others to IDLE. tck=0 and tms/tdi hold their last value after a command.
- len=0: no TCK pulses; SCAN ops respond immediately with rsp_data=0.
- enable falling mid-command: current command completes; it only gates new acceptance.
- Unused rsp_data bits above len are 0.

## Timing
- Reset values: tck=0, tms=0, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, stop=0, state WAIT_INIT.
- Async reset mid-command aborts immediately; no partial response.
- Each bit takes exactly 2·TCK_HALF clocks; first LOW phase starts the cycle after acceptance.
- Command of n bits: rsp_valid rises 2·TCK_HALF·n+1 clocks after acceptance.
- cmd_ready low from acceptance until return to IDLE; no pipelining of commands.
- tms/tdi change only while tck=0.

## Structure
- Package jtag_vpi_pkg: opcode constants, state enum.
- Sub-module jtag_vpi_bitclk: TCK_HALF down-counter producing phase-end strobes.

## Test plan
- Reset then init_done=1, enable=1: cmd_ready rises one clock after init_done; all outputs at reset values before that.
- RESET op: tms observed 1,1,1,1,1,0 at six tck rising edges, tdi=0; no response.
- SCAN len=8 data=0xA5, tdo looped from tdi: tdi LSB-first 1,0,1,0,0,1,0,1 with tms=0; rsp_data=0xA5 after 2·TCK_HALF·8+1 clocks.
- SCAN_FLIP_TMS len=4 data=0x3, tdo=1: tms=1 only on the 4th edge; rsp_data=0xF; rsp_valid held until rsp_ready.
- STOP op: stop high exactly one cycle, no tck activity, cmd_ready returns.
- enable=0 mid-SCAN len=16: command completes and response delivered; cmd_ready stays 0 until enable returns.

Source files
------------

// File: rtl/jtag_vpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_vpi_pkg
//  Description : Shared opcodes, state encoding and helpers for the JTAG
//                master (jtag_vpi_core and jtag_vpi_bitclk).
//  Contents    : c_OP_* opcodes, c_RESET_* TAP reset pattern, state_t,
//                is_scan_op() helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_vpi_pkg;

    // Host command opcodes (3-bit cmd_op field)
    localparam logic [2:0] c_OP_RESET         = 3'd0;
    localparam logic [2:0] c_OP_TMS_SEQ       = 3'd1;
    localparam logic [2:0] c_OP_SCAN          = 3'd2;
    localparam logic [2:0] c_OP_SCAN_FLIP_TMS = 3'd3;
    localparam logic [2:0] c_OP_STOP          = 3'd4;

    // TAP reset: five TMS=1 clocks reach Test-Logic-Reset, the final 0
    // parks the TAP in Run-Test/Idle. LSB is shifted first.
    localparam logic [5:0] c_RESET_TMS = 6'b011111;
    localparam logic [6:0] c_RESET_LEN = 7'd6;

    typedef enum logic [2:0] {
        ST_WAIT_INIT = 3'd0,
        ST_IDLE      = 3'd1,
        ST_LOW       = 3'd2,
        ST_HIGH      = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    // Only scan-type commands produce a response on the rsp channel.
    function automatic logic is_scan_op(input logic [2:0] op);
        return (op == c_OP_SCAN) || (op == c_OP_SCAN_FLIP_TMS);
    endfunction

endpackage : jtag_vpi_pkg
`default_nettype wire

// File: rtl/jtag_vpi_bitclk.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_vpi_bitclk
//  Description : TCK half-period timer. A down-counter that asserts
//                o_phase_end on the last system clock of every TCK half
//                period and reloads itself; i_restart realigns the count so
//                the first phase after a command is a full half period.
//  Ports       : i_clk, i_rst_n  - system clock, async active-low reset
//                i_restart       - reload counter (command acceptance)
//                o_phase_end     - high on the last clock of a half period
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_vpi_bitclk #(
    parameter int TCK_HALF = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_phase_end
);

    localparam int              c_CW     = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam logic [c_CW-1:0] c_RELOAD = c_CW'(TCK_HALF - 1);
    localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= c_RELOAD;
        end else if (i_restart || (r_cnt == '0)) begin
            r_cnt <= c_RELOAD;
        end else begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_phase_end = (r_cnt == '0);

endmodule : jtag_vpi_bitclk
`default_nettype wire

// File: rtl/jtag_vpi_core.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_vpi_core
//  Description : JTAG master. Converts host commands (TAP reset, TMS
//                sequence, scan, scan with TMS=1 on the last bit, stop) into
//                TCK/TMS/TDI bit sequences and captures TDO for scans.
//  Ports       : wb_clk_i, wb_rst_ni      - clock, async active-low reset
//                enable, init_done        - acceptance gate, sticky arm
//                cmd_valid/ready/op/len/data - command channel
//                rsp_valid/ready/data     - scan response channel
//                stop                     - one-cycle pulse on STOP
//                tck, tms, tdi, tdo       - JTAG pins
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_vpi_core
    import jtag_vpi_pkg::*;
#(
    parameter int TCK_HALF = 2,
    parameter int MAX_BITS = 64
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                enable,
    input  logic                init_done,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [6:0]          cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                stop,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    localparam int         c_IW      = $clog2(MAX_BITS);
    localparam logic [6:0] c_MAX_LEN = 7'(MAX_BITS);

    state_t              r_state;
    logic [2:0]          r_op;
    logic [6:0]          r_len;
    logic [6:0]          r_bit_idx;
    logic [MAX_BITS-1:0] r_data;
    logic [MAX_BITS-1:0] r_capture;
    logic                r_tck;
    logic                r_tms;
    logic                r_tdi;
    logic                r_rsp_valid;
    logic                r_stop;

    logic                w_accept;
    logic                w_phase_end;
    logic [6:0]          w_load_len;
    logic [MAX_BITS-1:0] w_load_data;
    logic [6:0]          w_next_idx;
    logic [1:0]          w_first_drive;
    logic [1:0]          w_next_drive;

    // {tms, tdi} for bit idx of a command. RESET is shifted exactly like a
    // TMS sequence once its fixed pattern has been loaded.
    function automatic logic [1:0] bit_drive(
        input logic [2:0]          op,
        input logic [MAX_BITS-1:0] data,
        input logic [6:0]          len,
        input logic [6:0]          idx
    );
        logic v_bit;
        v_bit = data[idx[c_IW-1:0]];
        case (op)
            c_OP_RESET, c_OP_TMS_SEQ: bit_drive = {v_bit, 1'b0};
            c_OP_SCAN:                bit_drive = {1'b0, v_bit};
            c_OP_SCAN_FLIP_TMS:       bit_drive = {(idx == len - 7'd1), v_bit};
            default:                  bit_drive = 2'b00;
        endcase
    endfunction

    // Acceptance is only possible from IDLE; enable gates new commands but
    // never interrupts one in flight.
    assign cmd_ready = (r_state == ST_IDLE) && enable;
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_load_len  = (cmd_len > c_MAX_LEN) ? c_MAX_LEN : cmd_len;
        w_load_data = cmd_data;
        if (cmd_op == c_OP_RESET) begin
            w_load_len  = c_RESET_LEN;
            w_load_data = {{(MAX_BITS-6){1'b0}}, c_RESET_TMS};
        end
    end

    assign w_next_idx    = r_bit_idx + 7'd1;
    assign w_first_drive = bit_drive(cmd_op, w_load_data, w_load_len, 7'd0);
    assign w_next_drive  = bit_drive(r_op, r_data, r_len, w_next_idx);

    jtag_vpi_bitclk #(
        .TCK_HALF (TCK_HALF)
    ) u_bitclk (
        .i_clk       (wb_clk_i),
        .i_rst_n     (wb_rst_ni),
        .i_restart   (w_accept),
        .o_phase_end (w_phase_end)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= ST_WAIT_INIT;
            r_op        <= '0;
            r_len       <= '0;
            r_bit_idx   <= '0;
            r_data      <= '0;
            r_capture   <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b0;
            r_tdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_stop      <= 1'b0;
        end else begin
            r_stop <= 1'b0;
            case (r_state)
                ST_WAIT_INIT: begin
                    if (init_done) r_state <= ST_IDLE;
                end

                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= cmd_op;
                        r_len     <= w_load_len;
                        r_data    <= w_load_data;
                        r_capture <= '0;
                        r_bit_idx <= '0;
                        case (cmd_op)
                            c_OP_STOP: r_stop <= 1'b1;
                            c_OP_RESET, c_OP_TMS_SEQ, c_OP_SCAN, c_OP_SCAN_FLIP_TMS: begin
                                if (w_load_len == 7'd0) begin
                                    // Zero-length: no TCK activity, scans answer at once.
                                    if (is_scan_op(cmd_op)) begin
                                        r_state     <= ST_RESP;
                                        r_rsp_valid <= 1'b1;
                                    end
                                end else begin
                                    r_state        <= ST_LOW;
                                    {r_tms, r_tdi} <= w_first_drive;
                                end
                            end
                            default: ; // unknown opcode: consumed, no action
                        endcase
                    end
                end

                ST_LOW: begin
                    // Leaving LOW is the rising TCK edge; TDO is sampled here.
                    if (w_phase_end) begin
                        r_state                 <= ST_HIGH;
                        r_tck                   <= 1'b1;
                        r_capture[r_bit_idx[c_IW-1:0]] <= tdo;
                    end
                end

                ST_HIGH: begin
                    if (w_phase_end) begin
                        r_tck <= 1'b0;
                        if (r_bit_idx == r_len - 7'd1) begin
                            // tms/tdi keep the last bit's value after the command.
                            if (is_scan_op(r_op)) begin
                                r_state     <= ST_RESP;
                                r_rsp_valid <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_state        <= ST_LOW;
                            r_bit_idx      <= w_next_idx;
                            {r_tms, r_tdi} <= w_next_drive;
                        end
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: r_state <= ST_WAIT_INIT;
            endcase
        end
    end

    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_capture;
    assign stop      = r_stop;

endmodule : jtag_vpi_core
`default_nettype wire

// File: tb/tb_jtag_vpi_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_vpi_core
//  Description : Scoreboard bench for jtag_vpi_core (TCK_HALF=2,
//                MAX_BITS=64). Stimulus pushes expected TCK-edge pin values,
//                response data and response latency into queues; a monitor
//                on the falling system clock edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_vpi_core;

    localparam int         c_HALF   = 2;
    localparam logic [2:0] c_RESET  = 3'd0;
    localparam logic [2:0] c_TMS    = 3'd1;
    localparam logic [2:0] c_SCAN   = 3'd2;
    localparam logic [2:0] c_FLIP   = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, init_done;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [6:0]  cmd_len;
    logic [63:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic        stop, tck, tms, tdi, tdo;
    logic        tdo_loop, tdo_val;

    assign tdo = tdo_loop ? tdi : tdo_val;

    jtag_vpi_core #(
        .TCK_HALF (c_HALF),
        .MAX_BITS (64)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .enable    (enable),
        .init_done (init_done),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .stop      (stop),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cycle = 0;
    int stop_count = 0;

    logic [1:0]  edge_q[$];
    logic [63:0] rsp_q[$];
    int          lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------------------------------------------------------- monitor
    logic       prev_tck = 1'b0;
    logic       prev_rv  = 1'b0;
    logic [1:0] prev_pins = 2'b00;

    always @(negedge clk) begin
        logic [1:0]  e_pins;
        logic [63:0] e_data;
        int          e_lat;
        if (tck && !prev_tck) begin
            if (edge_q.size() == 0) fail("tck_unexpected_edge");
            else begin
                e_pins = edge_q.pop_front();
                check("tck_edge_tms_tdi", {62'd0, tms, tdi}, {62'd0, e_pins});
            end
        end
        if (tck && prev_tck && ({tms, tdi} != prev_pins))
            fail("pins_changed_while_tck_high");
        if (rsp_valid && !prev_rv) begin
            if (lat_q.size() == 0) fail("rsp_unexpected");
            else begin
                e_lat = lat_q.pop_front();
                check("rsp_latency", 64'(cyc - acc_cycle), 64'(e_lat));
            end
        end
        if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) fail("rsp_data_unexpected");
            else begin
                e_data = rsp_q.pop_front();
                check("rsp_data", rsp_data, e_data);
            end
        end
        if (stop) stop_count++;
        prev_tck  = tck;
        prev_rv   = rsp_valid;
        prev_pins = {tms, tdi};
    end

    // --------------------------------------------------------------- helpers
    // Expected {tms,tdi} at each rising TCK edge, LSB of data first.
    task automatic push_edges(input logic [2:0] op, input int n, input logic [63:0] data);
        for (int i = 0; i < n; i++) begin
            logic t, d;
            t = 1'b0;
            d = 1'b0;
            case (op)
                c_TMS:  t = data[i];
                c_SCAN: d = data[i];
                c_FLIP: begin t = (i == n - 1); d = data[i]; end
                default: ;
            endcase
            edge_q.push_back({t, d});
        end
    endtask

    task automatic push_rsp(input logic [63:0] data, input int lat);
        rsp_q.push_back(data);
        lat_q.push_back(lat);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) fail(name);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [6:0] len,
                            input logic [63:0] data, input logic busy_expected);
        wait_ready("cmd_ready_timeout");
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        acc_cycle = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = '0;
        if (busy_expected) check("busy_after_accept", {63'd0, cmd_ready}, 64'd0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || edge_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || edge_q.size() != 0) fail(name);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        init_done = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        tdo_loop  = 1'b1;
        tdo_val   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tck",       {63'd0, tck},       64'd0);
        check("rst_tms",       {63'd0, tms},       64'd0);
        check("rst_tdi",       {63'd0, tdi},       64'd0);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data",  rsp_data,           64'd0);
        check("rst_stop",      {63'd0, stop},      64'd0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ready_in_wait_init", {63'd0, cmd_ready}, 64'd0);
        init_done = 1'b1;
        #1 check("ready_same_cycle_as_init", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        check("ready_after_init", {63'd0, cmd_ready}, 64'd1);

        // RESET: TMS 1,1,1,1,1,0 with TDI 0, no response
        repeat (5) edge_q.push_back(2'b10);
        edge_q.push_back(2'b00);
        send_cmd(c_RESET, 7'd0, 64'd0, 1'b1);
        wait_drain("reset_op_drain");

        // SCAN 8 bits 0xA5, TDO looped: 2*2*8+1 = 33 clocks to response
        tdo_loop = 1'b1;
        push_edges(c_SCAN, 8, 64'hA5);
        push_rsp(64'hA5, 33);
        send_cmd(c_SCAN, 7'd8, 64'hA5, 1'b1);
        wait_drain("scan_a5_drain");

        // SCAN_FLIP_TMS 4 bits 0x3, TDO=1, response held while rsp_ready=0
        tdo_loop  = 1'b0;
        tdo_val   = 1'b1;
        rsp_ready = 1'b0;
        push_edges(c_FLIP, 4, 64'h3);
        push_rsp(64'hF, 17);
        send_cmd(c_FLIP, 7'd4, 64'h3, 1'b1);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
            if (!rsp_valid) fail("flip_rsp_timeout");
        end
        repeat (5) begin
            @(negedge clk);
            check("rsp_valid_held", {63'd0, rsp_valid}, 64'd1);
        end
        check("ready_low_during_resp", {63'd0, cmd_ready}, 64'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_drain("flip_drain");
        wait_ready("flip_ready");

        // STOP: single-cycle pulse, no TCK, ready comes straight back
        stop_count = 0;
        send_cmd(c_STOP, 7'd0, 64'd0, 1'b0);
        check("stop_after_accept", {63'd0, stop}, 64'd1);
        repeat (4) @(negedge clk);
        check("stop_pulse_cycles", 64'(stop_count), 64'd1);
        check("ready_after_stop", {63'd0, cmd_ready}, 64'd1);

        // Unknown opcode: consumed silently
        send_cmd(3'd6, 7'd5, 64'h1F, 1'b0);
        repeat (4) @(negedge clk);
        check("ready_after_unknown", {63'd0, cmd_ready}, 64'd1);
        check("no_stop_on_unknown", 64'(stop_count), 64'd1);

        // TMS_SEQ 5 bits 0b10110: TMS 0,1,1,0,1 with TDI 0
        push_edges(c_TMS, 5, 64'h16);
        send_cmd(c_TMS, 7'd5, 64'h16, 1'b1);
        wait_drain("tms_seq_drain");

        // len=0 SCAN: immediate response with zero data
        tdo_loop = 1'b1;
        push_rsp(64'd0, 1);
        send_cmd(c_SCAN, 7'd0, 64'hFF, 1'b1);
        wait_drain("scan_len0_drain");

        // len above MAX_BITS clamps to 64 bits: 2*2*64+1 = 257 clocks
        push_edges(c_SCAN, 64, 64'h0123_4567_89AB_CDEF);
        push_rsp(64'h0123_4567_89AB_CDEF, 257);
        send_cmd(c_SCAN, 7'd100, 64'h0123_4567_89AB_CDEF, 1'b1);
        wait_drain("scan_clamp_drain");

        // enable dropped mid-SCAN of 16 bits: command still completes
        push_edges(c_SCAN, 16, 64'hBEEF);
        push_rsp(64'hBEEF, 65);
        send_cmd(c_SCAN, 7'd16, 64'hBEEF, 1'b1);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_drain("enable_drop_drain");
        repeat (3) begin
            @(negedge clk);
            check("ready_gated_by_enable", {63'd0, cmd_ready}, 64'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("ready_after_enable", {63'd0, cmd_ready}, 64'd1);

        // Async reset mid-SCAN: outputs clear at once, no response follows
        push_edges(c_SCAN, 8, 64'h3C);
        push_rsp(64'h3C, 33);
        send_cmd(c_SCAN, 7'd8, 64'h3C, 1'b1);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tck",       {63'd0, tck},       64'd0);
        check("abort_tms_tdi",   {62'd0, tms, tdi},  64'd0);
        check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("abort_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        edge_q.delete();
        rsp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("post_abort_rsp_data",  rsp_data,           64'd0);
        check("post_abort_ready",     {63'd0, cmd_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_jtag_vpi_core
`default_nettype wire
